// File: rtl/zap_lmult_unit_pkg.sv
// Shared definitions for the long-multiply unit: FSM encoding, micro-op tag bit
// and the LMULT instruction field positions that predecode already relies on.
package zap_lmult_unit_pkg;

  localparam int MUL_STEPS = 4;
  localparam logic [1:0] LAST_STEP = 2'(MUL_STEPS - 1);

  // Bit 35 of the expanded micro-op selects the high half of the product.
  localparam int TAG_BIT = 35;

  localparam int LM_RDHI_MSB   = 19;
  localparam int LM_RDHI_LSB   = 16;
  localparam int LM_RDLO_MSB   = 15;
  localparam int LM_RDLO_LSB   = 12;
  localparam int LM_RS_MSB     = 11;
  localparam int LM_RS_LSB     = 8;
  localparam int LM_RM_MSB     = 3;
  localparam int LM_RM_LSB     = 0;
  localparam int LM_SIGNED_BIT = 22;
  localparam int LM_ACC_BIT    = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } lm_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/zap_lmult_unit_if.sv
// Issue-side bundle for the long-multiply unit, plus FSM/cache debug taps.
interface zap_lmult_unit_if;
  import zap_lmult_unit_pkg::*;

  // Handshake: i_start is "valid" for the presented micro-op; o_busy is the
  // inverse of "ready" and holds issue until o_done pulses, at which point
  // o_rd is valid for that cycle and the micro-op is retired.
  logic        i_clear_from_writeback;
  logic        i_clear_from_alu;
  logic        i_data_stall;
  logic        i_start;
  logic        i_high;
  logic        i_signed;
  logic        i_accumulate;
  logic [31:0] i_rm;
  logic [31:0] i_rs;
  logic [31:0] i_rn;
  logic [31:0] i_rh;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rd;
  lm_state_e   dbg_state;
  logic        dbg_cache_valid;

  modport master (
    output i_clear_from_writeback, i_clear_from_alu, i_data_stall, i_start,
           i_high, i_signed, i_accumulate, i_rm, i_rs, i_rn, i_rh,
    input  o_busy, o_done, o_rd, dbg_state, dbg_cache_valid
  );

  modport slave (
    input  i_clear_from_writeback, i_clear_from_alu, i_data_stall, i_start,
           i_high, i_signed, i_accumulate, i_rm, i_rs, i_rn, i_rh,
    output o_busy, o_done, o_rd, dbg_state, dbg_cache_valid
  );

endinterface

// File: rtl/zap_lmult_step.sv
// One 32x8 unsigned partial product, shifted into byte lane i_shift and added
// to the running 64-bit accumulator.
module zap_lmult_step (
  input  logic [31:0] i_a,
  input  logic [7:0]  i_b,
  input  logic [1:0]  i_shift,
  input  logic [63:0] i_acc,
  output logic [63:0] o_sum
);

  logic [39:0] pp;
  logic [63:0] pp_ext;

  assign pp     = {8'd0, i_a} * {32'd0, i_b};
  assign pp_ext = {24'd0, pp} << {i_shift, 3'b000};
  assign o_sum  = i_acc + pp_ext;

endmodule

// File: rtl/zap_lmult_unit.sv
// Iterative long multiplier (UMULL/SMULL/UMLAL/SMLAL micro-op pair).
// ZAP_LMULT_CACHE_EN adds a product cache so the high micro-op can hit.
module zap_lmult_unit
  import zap_lmult_unit_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  zap_lmult_unit_if.slave lm
);

  lm_state_e   state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [31:0] rm_mag_q, rm_mag_d;
  logic [31:0] rs_mag_q, rs_mag_d;
  logic        neg_q, neg_d;
  logic        high_q, high_d;
  logic        acc_q, acc_d;
  logic [31:0] rn_q, rn_d;
  logic [31:0] rh_q, rh_d;
  logic [63:0] prod_q, prod_d;
  logic        done_q, done_d;
  logic [31:0] rd_q, rd_d;

  logic        cache_valid;
  logic        cache_hit;
  logic [7:0]  rs_byte;
  logic [63:0] step_sum;
  logic [63:0] fix_prod;
  logic        flush;
  logic        hold;

  // A stalled pipe outranks the ALU flush but not the writeback flush.
  assign flush = lm.i_clear_from_writeback | (lm.i_clear_from_alu & ~lm.i_data_stall);
  assign hold  = lm.i_data_stall;

`ifdef ZAP_LMULT_CACHE_EN
  logic        cv_q, cv_d;
  logic [31:0] tag_rm_q, tag_rm_d;
  logic [31:0] tag_rs_q, tag_rs_d;
  logic        tag_sgn_q, tag_sgn_d;

  assign cache_valid = cv_q;
  assign cache_hit   = lm.i_high & cv_q &
                       (tag_rm_q == lm.i_rm) & (tag_rs_q == lm.i_rs) &
                       (tag_sgn_q == lm.i_signed) & (acc_q == lm.i_accumulate) &
                       (rn_q == lm.i_rn) & (rh_q == lm.i_rh);
`else
  assign cache_valid = 1'b0;
  assign cache_hit   = 1'b0;
`endif

  always_comb begin
    rs_byte = rs_mag_q[7:0];
    case (step_q)
      2'd1:    rs_byte = rs_mag_q[15:8];
      2'd2:    rs_byte = rs_mag_q[23:16];
      2'd3:    rs_byte = rs_mag_q[31:24];
      default: rs_byte = rs_mag_q[7:0];
    endcase
  end

  zap_lmult_step u_step (
    .i_a     (rm_mag_q),
    .i_b     (rs_byte),
    .i_shift (step_q),
    .i_acc   (prod_q),
    .o_sum   (step_sum)
  );

  assign fix_prod = (neg_q ? (~prod_q + 64'd1) : prod_q) +
                    (acc_q ? {rh_q, rn_q} : 64'd0);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    rm_mag_d = rm_mag_q;
    rs_mag_d = rs_mag_q;
    neg_d    = neg_q;
    high_d   = high_q;
    acc_d    = acc_q;
    rn_d     = rn_q;
    rh_d     = rh_q;
    prod_d   = prod_q;
    done_d   = 1'b0;
    rd_d     = rd_q;
`ifdef ZAP_LMULT_CACHE_EN
    cv_d      = cv_q;
    tag_rm_d  = tag_rm_q;
    tag_rs_d  = tag_rs_q;
    tag_sgn_d = tag_sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (lm.i_start) begin
          if (cache_hit) begin
            high_d  = 1'b1;
            rd_d    = prod_q[63:32];
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            rm_mag_d = lm.i_signed ? mag32(lm.i_rm) : lm.i_rm;
            rs_mag_d = lm.i_signed ? mag32(lm.i_rs) : lm.i_rs;
            neg_d    = lm.i_signed & (lm.i_rm[31] ^ lm.i_rs[31]);
            high_d   = lm.i_high;
            acc_d    = lm.i_accumulate;
            rn_d     = lm.i_rn;
            rh_d     = lm.i_rh;
            prod_d   = '0;
            step_d   = '0;
            state_d  = MUL;
`ifdef ZAP_LMULT_CACHE_EN
            // prod_q is about to be overwritten, so the old entry dies here.
            cv_d      = 1'b0;
            tag_rm_d  = lm.i_rm;
            tag_rs_d  = lm.i_rs;
            tag_sgn_d = lm.i_signed;
`endif
          end
        end
      end
      MUL: begin
        prod_d = step_sum;
        step_d = step_q + 2'd1;
        if (step_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        prod_d  = fix_prod;
        rd_d    = high_q ? fix_prod[63:32] : fix_prod[31:0];
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
`ifdef ZAP_LMULT_CACHE_EN
        cv_d = ~high_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
`ifdef ZAP_LMULT_CACHE_EN
      cv_q    <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
`ifdef ZAP_LMULT_CACHE_EN
      cv_q    <= 1'b0;
`endif
    end else if (!hold) begin
      state_q <= state_d;
      done_q  <= done_d;
`ifdef ZAP_LMULT_CACHE_EN
      cv_q    <= cv_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      step_q   <= '0;
      rm_mag_q <= '0;
      rs_mag_q <= '0;
      neg_q    <= 1'b0;
      high_q   <= 1'b0;
      acc_q    <= 1'b0;
      rn_q     <= '0;
      rh_q     <= '0;
      prod_q   <= '0;
      rd_q     <= '0;
`ifdef ZAP_LMULT_CACHE_EN
      tag_rm_q  <= '0;
      tag_rs_q  <= '0;
      tag_sgn_q <= 1'b0;
`endif
    end else if (!flush && !hold) begin
      step_q   <= step_d;
      rm_mag_q <= rm_mag_d;
      rs_mag_q <= rs_mag_d;
      neg_q    <= neg_d;
      high_q   <= high_d;
      acc_q    <= acc_d;
      rn_q     <= rn_d;
      rh_q     <= rh_d;
      prod_q   <= prod_d;
      rd_q     <= rd_d;
`ifdef ZAP_LMULT_CACHE_EN
      tag_rm_q  <= tag_rm_d;
      tag_rs_q  <= tag_rs_d;
      tag_sgn_q <= tag_sgn_d;
`endif
    end
  end

  assign lm.o_busy          = lm.i_start & ~done_q;
  assign lm.o_done          = done_q;
  assign lm.o_rd            = rd_q;
  assign lm.dbg_state       = state_q;
  assign lm.dbg_cache_valid = cache_valid;

endmodule
